// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM state encodings and small helpers for the SPI flash responder.
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0b;
    localparam logic [7:0] CMD_JEDEC_ID  = 8'h9f;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_DUMMY  = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_ID     = 3'd5;
    localparam state_t ST_IGNORE = 3'd6;

    // Bytes past the three ID bytes read back as zero.
    function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            2'd2:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic drives_sdo(input state_t s);
        return (s == ST_DATA) || (s == ST_ID);
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync_1bit.sv
// Flop-chain synchroniser for one asynchronous SPI pin, with a configurable idle/reset level.
module spi_flash_responder_sync_1bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= {STAGES{RST_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash responder (mode 0) serving READ and JEDEC-ID from a byte-wide memory port.
// Optional FAST_READ (0x0B) support is enabled by defining SPI_FLASH_RESPONDER_FAST_READ_EN.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int          W_ADDR      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hef4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic [W_ADDR-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    // Pin order {sdi, cs_n, sclk}; idle levels sclk=0, cs_n=1.
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] pins_raw;
    logic [2:0] pins_sync;
    logic       sclk_s, cs_n_s, sdi_s;

    assign pins_raw = {spi_sdi, spi_cs_n, spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_flash_responder_sync_1bit #(
                .STAGES  (SYNC_STAGES),
                .RST_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (pins_raw[gi]),
                .q   (pins_sync[gi])
            );
        end
    endgenerate

    assign sclk_s = pins_sync[0];
    assign cs_n_s = pins_sync[1];
    assign sdi_s  = pins_sync[2];

    state_t                 state_reg, state_next;
    logic                   sclk_prev_reg;
    logic [SYNC_STAGES-1:0] primed_reg;
    logic                   armed_reg;
    logic [4:0]             bit_cnt_reg;
    logic [6:0]             shift_in_reg;
    logic [22:0]            addr_reg;
    logic [7:0]             shift_out_reg;
    logic [7:0]             prefetch_reg;
    logic                   fast_reg;
    logic [W_ADDR-1:0]      mem_addr_reg;
    logic                   mem_ren_reg;
    logic                   ren_d_reg;
    logic                   sdo_reg;
    logic                   sdo_oe_reg;

    logic        sclk_rise, sclk_fall;
    logic [7:0]  opcode;
    logic [23:0] spi_addr;
    logic [7:0]  id_byte;

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign opcode    = {shift_in_reg, sdi_s};
    assign spi_addr  = {addr_reg, sdi_s};
    assign id_byte   = jedec_byte(JEDEC_ID, bit_cnt_reg[4:3]);

    always_comb begin
        state_next = state_reg;
        if (cs_n_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                // armed_reg blocks a frame already in progress when reset was released.
                ST_IDLE: if (armed_reg) state_next = ST_CMD;
                ST_CMD: begin
                    if (sclk_rise && bit_cnt_reg == 5'd7) begin
                        case (opcode)
                            CMD_READ:      state_next = ST_ADDR;
                            CMD_JEDEC_ID:  state_next = ST_ID;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                            CMD_FAST_READ: state_next = ST_ADDR;
`else
                            CMD_FAST_READ: state_next = ST_IGNORE;
`endif
                            default:       state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise && bit_cnt_reg == 5'd23) begin
                        state_next = fast_reg ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: if (sclk_rise && bit_cnt_reg == 5'd7) state_next = ST_DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            sclk_prev_reg <= 1'b0;
            primed_reg    <= '0;
            armed_reg     <= 1'b0;
            bit_cnt_reg   <= '0;
            shift_in_reg  <= '0;
            addr_reg      <= '0;
            shift_out_reg <= '0;
            prefetch_reg  <= '0;
            fast_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_ren_reg   <= 1'b0;
            ren_d_reg     <= 1'b0;
            sdo_reg       <= 1'b0;
            sdo_oe_reg    <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            primed_reg    <= {primed_reg[SYNC_STAGES-2:0], 1'b1};
            if (primed_reg[SYNC_STAGES-1] && cs_n_s) armed_reg <= 1'b1;
            state_reg  <= state_next;
            sdo_oe_reg <= drives_sdo(state_next);
            mem_ren_reg <= 1'b0;
            ren_d_reg   <= mem_ren_reg;
            if (ren_d_reg) prefetch_reg <= mem_rdata;

            if (cs_n_s) begin
                bit_cnt_reg <= '0;
                sdo_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_in_reg <= {shift_in_reg[5:0], sdi_s};
                            fast_reg     <= (state_next == ST_ADDR) && (opcode == CMD_FAST_READ);
                            bit_cnt_reg  <= (bit_cnt_reg == 5'd7) ? 5'd0 : bit_cnt_reg + 5'd1;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr_reg <= {addr_reg[21:0], sdi_s};
                            if (bit_cnt_reg == 5'd23) begin
                                bit_cnt_reg  <= '0;
                                mem_addr_reg <= spi_addr[W_ADDR-1:0];
                                mem_ren_reg  <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sclk_rise) begin
                            bit_cnt_reg <= (bit_cnt_reg == 5'd7) ? 5'd0 : bit_cnt_reg + 5'd1;
                        end
                    end
                    ST_DATA: begin
                        if (sclk_fall) begin
                            // Byte boundary: present the prefetched byte and fetch the next one.
                            if (bit_cnt_reg[2:0] == 3'd0) begin
                                shift_out_reg <= prefetch_reg;
                                sdo_reg       <= prefetch_reg[7];
                                mem_addr_reg  <= mem_addr_reg + W_ADDR'(1);
                                mem_ren_reg   <= 1'b1;
                            end else begin
                                shift_out_reg <= {shift_out_reg[6:0], 1'b0};
                                sdo_reg       <= shift_out_reg[6];
                            end
                            bit_cnt_reg <= {2'b00, bit_cnt_reg[2:0] + 3'd1};
                        end
                    end
                    ST_ID: begin
                        if (sclk_fall) begin
                            if (bit_cnt_reg[2:0] == 3'd0) begin
                                shift_out_reg <= id_byte;
                                sdo_reg       <= id_byte[7];
                            end else begin
                                shift_out_reg <= {shift_out_reg[6:0], 1'b0};
                                sdo_reg       <= shift_out_reg[6];
                            end
                            // Park in the fourth byte slot so trailing bytes stay zero.
                            bit_cnt_reg <= (bit_cnt_reg == 5'd31) ? 5'd24 : bit_cnt_reg + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_sdo    = sdo_reg;
    assign spi_sdo_oe = sdo_oe_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_ren    = mem_ren_reg;
    assign busy       = ~cs_n_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: drives mode-0 SPI frames and a 1-cycle-latency memory.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic [23:0] mem_addr;
    logic        mem_ren;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          ren_cnt = 0;
    int          oe_cnt = 0;
    logic [23:0] ren_log [0:255];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe),
        .mem_addr   (mem_addr),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Memory model and activity monitors.
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= mem_addr[7:0] ^ 8'ha5;
            ren_log[ren_cnt[7:0]] <= mem_addr;
            ren_cnt <= ren_cnt + 1;
        end
        if (spi_sdo_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        wait_clks(5);
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        wait_clks(5);
        spi_sclk = 1'b0;
        wait_clks(10);
    endtask

    // MSB-first transfer of nbits; sdo is sampled just before each rising edge.
    // hold_high leaves SCLK high after the final bit so CS can rise before the last fall.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit hold_high,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sdi = tx[i];
            wait_clks(5);
            rx[i] = spi_sdo;
            spi_sclk = 1'b1;
            wait_clks(5);
            if (!(hold_high && i == 8 - nbits)) spi_sclk = 1'b0;
        end
    endtask

    task automatic read_frame(input string tag, input logic [23:0] addr, input int nbytes);
        int          ren0;
        logic [7:0]  rx;
        logic [23:0] a;
        ren0 = ren_cnt;
        cs_start();
        xfer(8'h03, 8, 1'b0, rx);
        xfer(addr[23:16], 8, 1'b0, rx);
        xfer(addr[15:8], 8, 1'b0, rx);
        xfer(addr[7:0], 8, 1'b0, rx);
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 24'(k);
            exp_q.push_back(a[7:0] ^ 8'ha5);
            xfer(8'h00, 8, k == nbytes - 1, rx);
            check_val({tag, "_data"}, {24'h0, rx}, {24'h0, exp_q.pop_front()});
        end
        cs_end();
        check_val({tag, "_ren_cnt"}, ren_cnt - ren0, nbytes + 1);
        for (int k = 0; k <= nbytes; k++) begin
            a = addr + 24'(k);
            check_val({tag, "_ren_addr"}, {8'h0, ren_log[8'(ren0 + k)]}, {8'h0, a});
        end
        check_val({tag, "_oe_after"}, {31'h0, spi_sdo_oe}, 32'h0);
        $display("[TB] %s: READ addr 0x%06h, %0d bytes", tag, addr, nbytes);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] id_exp [4];
        int         ren0, oe0;

        wait_clks(5);
        rst = 1'b0;
        wait_clks(1);
        check_val("rst_sdo", {31'h0, spi_sdo}, 32'h0);
        check_val("rst_oe", {31'h0, spi_sdo_oe}, 32'h0);
        check_val("rst_ren", {31'h0, mem_ren}, 32'h0);
        check_val("rst_addr", {8'h0, mem_addr}, 32'h0);
        check_val("rst_busy", {31'h0, busy}, 32'h0);
        wait_clks(10);
        $display("[TB] reset: outputs checked");

        read_frame("read10", 24'h000010, 3);

        // JEDEC ID
        ren0 = ren_cnt;
        id_exp[0] = 8'hef; id_exp[1] = 8'h40; id_exp[2] = 8'h18; id_exp[3] = 8'h00;
        cs_start();
        check_val("busy_in_frame", {31'h0, busy}, 32'h1);
        xfer(8'h9f, 8, 1'b0, rx);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(id_exp[k]);
            xfer(8'h00, 8, k == 3, rx);
            check_val("jedec_data", {24'h0, rx}, {24'h0, exp_q.pop_front()});
        end
        cs_end();
        check_val("jedec_ren", ren_cnt - ren0, 0);
        $display("[TB] jedec: 4 bytes");

        // Frame aborted after 12 address bits, then a clean READ.
        ren0 = ren_cnt;
        oe0 = oe_cnt;
        cs_start();
        xfer(8'h03, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'hf0, 4, 1'b0, rx);
        cs_end();
        check_val("abort_ren", ren_cnt - ren0, 0);
        check_val("abort_oe", oe_cnt - oe0, 0);
        check_val("abort_oe_now", {31'h0, spi_sdo_oe}, 32'h0);
        $display("[TB] abort: 12 address bits then CS high");
        read_frame("read100", 24'h000100, 2);

        read_frame("wrap", 24'hfffffe, 3);

        // Unknown opcode is ignored.
        ren0 = ren_cnt;
        oe0 = oe_cnt;
        cs_start();
        xfer(8'h02, 8, 1'b0, rx);
        for (int k = 0; k < 4; k++) xfer(8'hff, 8, k == 3, rx);
        cs_end();
        check_val("ignore_ren", ren_cnt - ren0, 0);
        check_val("ignore_oe", oe_cnt - oe0, 0);
        $display("[TB] ignore: opcode 0x02 + 32 clocks");
        read_frame("after_ign", 24'h000040, 2);

        // FAST_READ
        ren0 = ren_cnt;
        oe0 = oe_cnt;
        cs_start();
        xfer(8'h0b, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h20, 8, 1'b0, rx);
        xfer(8'hff, 8, 1'b0, rx);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'(8'h20 + k) ^ 8'ha5);
            xfer(8'h00, 8, k == 1, rx);
            check_val("fast_data", {24'h0, rx}, {24'h0, exp_q.pop_front()});
        end
        cs_end();
        check_val("fast_ren", ren_cnt - ren0, 3);
        check_val("fast_ren_addr", {8'h0, ren_log[8'(ren0)]}, 32'h20);
`else
        for (int k = 0; k < 2; k++) xfer(8'h00, 8, k == 1, rx);
        cs_end();
        check_val("fast_off_ren", ren_cnt - ren0, 0);
        check_val("fast_off_oe", oe_cnt - oe0, 0);
`endif
        $display("[TB] fast_read: opcode 0x0b addr 0x20");

        // Reset in the middle of DATA; the rest of that frame must be ignored.
        cs_start();
        xfer(8'h03, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h30, 8, 1'b0, rx);
        exp_q.push_back(8'h30 ^ 8'ha5);
        xfer(8'h00, 8, 1'b0, rx);
        check_val("pre_rst_data", {24'h0, rx}, {24'h0, exp_q.pop_front()});
        xfer(8'h00, 3, 1'b0, rx);
        rst = 1'b1;
        wait_clks(1);
        check_val("midrst_sdo", {31'h0, spi_sdo}, 32'h0);
        check_val("midrst_oe", {31'h0, spi_sdo_oe}, 32'h0);
        check_val("midrst_ren", {31'h0, mem_ren}, 32'h0);
        check_val("midrst_addr", {8'h0, mem_addr}, 32'h0);
        check_val("midrst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        ren0 = ren_cnt;
        oe0 = oe_cnt;
        xfer(8'h03, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h55, 8, 1'b0, rx);
        cs_end();
        check_val("postrst_ren", ren_cnt - ren0, 0);
        check_val("postrst_oe", oe_cnt - oe0, 0);
        $display("[TB] mid-data reset: frame remainder ignored");
        read_frame("after_rst", 24'h000050, 1);

        check_val("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
